arm_alu: RTL and testbench
==========================

// Module: arm_alu
// PURPOSE
//  Integer ALU of the single-cycle ARMv4-subset core; sits in the datapath after the SrcB mux.
//  Computes ADD/SUB/AND/ORR on two WIDTH-bit operands; result and NZCV flags are combinational.
//  Result feeds the address path, register write-back and PC mux in the same cycle.
//  Also holds a registered NZCV status copy (flags_q) with split NZ / CV write enables.
// PARAMETERS
//  WIDTH  32  operand/result width in bits
// PORTS
//  clk          in   1      clock; flags_q updates on rising edge
//  reset        in   1      asynchronous, active-high; clears flags_q
//  src_a        in   WIDTH  operand A (Rn or PC+8)
//  src_b        in   WIDTH  operand B (Rm or extended immediate)
//  alu_control  in   2      00 ADD, 01 SUB, 10 AND, 11 ORR
//  flag_we      in   2      [1] writes N,Z into flags_q; [0] writes C,V into flags_q
//  alu_result   out  WIDTH  combinational result
//  alu_flags    out  4      combinational {N,Z,C,V} of the current operation
//  flags_q      out  4      registered {N,Z,C,V}
// BEHAVIOUR
//  - ADD: sum = src_a + src_b. Computed at WIDTH+1 bits; C = carry-out bit WIDTH.
//  - SUB: sum = src_a + ~src_b + 1, also at WIDTH+1 bits. C = carry-out, so C=1 means no borrow (src_a >= src_b unsigned).
//  - AND: src_a & src_b.  ORR: src_a | src_b.  C=0 and V=0 for both logic ops.
//  - N = alu_result[WIDTH-1]; Z = (alu_result == 0). These apply to all ops.
//  - V (ADD/SUB only) = ~(src_a[MSB] ^ src_b[MSB] ^ alu_control[0]) & (src_a[MSB] ^ sum[MSB]).
//  - Arithmetic wraps modulo 2^WIDTH; no saturation.
//  - alu_result and alu_flags have zero-cycle latency and no dependence on clk or reset.
//  - X or undefined alu_control is unreachable in the core; the design drives result and flags as for ADD.
//  - flags_q reset value is 4'b0000, applied immediately on reset assertion.
//  - Rising clk with reset low:
//      flag_we[1] -> flags_q[3:2] <= alu_flags[3:2]
//      flag_we[0] -> flags_q[1:0] <= alu_flags[1:0]
//      bits whose enable is low hold their value.
//  - flag_we=2'b11 updates all four bits in the same edge.
//  - Reset mid-operation clears only flags_q; combinational outputs keep tracking their inputs.
//  - No handshake; inputs are assumed valid every cycle.
// STRUCTURE
//  - Package arm_alu_pkg:
//      enum alu_op_e {ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_ORR=2'b11}
//      flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
//  - One sub-module arm_alu_addsub, shared by ADD and SUB:
//      inputs a, b, sub; outputs sum[WIDTH-1:0], cout, ovf.
//      Implemented as a + (sub ? ~b : b) + sub.
//  - Top level: op mux, flag generation, and two enable flops for NZ and CV.
// TESTING
//  - ADD 5 + 7 -> result 0x0000000C, flags 0000.
//  - SUB 7 - 7 -> result 0, flags N0 Z1 C1 V0. SUB 3 - 5 -> 0xFFFFFFFE, flags N1 Z0 C0 V0.
//  - ADD 0x7FFFFFFF + 1 -> 0x80000000, flags 1001. ADD 0xFFFFFFFF + 1 -> 0, flags 0110.
//  - AND 0x0000F0F0 & 0x0000FF00 -> 0x0000F000, flags 0000.
//  - ORR 0x80000000 | 1 -> 0x80000001, flags 1000.
//  - flags_q sequence:
//      assert reset -> 0000
//      SUB 7-7 with flag_we=10 -> 0100
//      ADD 0xFFFFFFFF+1 with flag_we=01 -> 0110
//      flag_we=00 on any op -> holds 0110
//      async reset pulse between edges -> 0000 immediately.

Source files
------------

// File: rtl/arm_alu_pkg.sv
// Shared types and constants for the ARMv4-subset integer ALU.
// Operation encodings and NZCV bit positions used by the RTL and the bench.
package arm_alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/arm_alu_if.sv
// Operand/result bundle between the core datapath and the ALU.
// The datapath drives operands and controls; the ALU returns result and flags.
interface arm_alu_if #(
  parameter int WIDTH = 32
);

  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [1:0]       alu_control;
  logic [1:0]       flag_we;
  logic [WIDTH-1:0] alu_result;
  logic [3:0]       alu_flags;
  logic [3:0]       flags_q;

  modport master (
    output src_a, src_b, alu_control, flag_we,
    input  alu_result, alu_flags, flags_q
  );

  modport slave (
    input  src_a, src_b, alu_control, flag_we,
    output alu_result, alu_flags, flags_q
  );

endinterface

// File: rtl/arm_alu_addsub.sv
// Shared adder/subtractor: a + (sub ? ~b : b) + sub at WIDTH+1 bits.
// Carry-out doubles as the ARM "no borrow" flag when subtracting.
module arm_alu_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] bOperand;
  logic [WIDTH:0]   wideSum;

  assign bOperand = sub ? ~b : b;
  assign wideSum  = {1'b0, a} + {1'b0, bOperand} + {{WIDTH{1'b0}}, sub};
  assign sum      = wideSum[WIDTH-1:0];
  assign cout     = wideSum[WIDTH];

  // Overflow when the effective operands share a sign that the sum does not.
  assign ovf = ~(a[WIDTH-1] ^ b[WIDTH-1] ^ sub) & (a[WIDTH-1] ^ sum[WIDTH-1]);

endmodule

// File: rtl/arm_alu.sv
// Integer ALU for the single-cycle core: combinational result and NZCV,
// plus a registered NZCV copy with separate NZ and CV write enables.
module arm_alu
  import arm_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      reset,
  arm_alu_if.slave  alu_bus
);

  logic             isSub;
  logic             isArith;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic [1:0]       nz_d, nz_q;
  logic [1:0]       cv_d, cv_q;

  assign isSub = (alu_bus.alu_control == ALU_SUB);

  arm_alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a    (alu_bus.src_a),
    .b    (alu_bus.src_b),
    .sub  (isSub),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  // Anything that is not a logic op falls back to the adder path.
  always_comb begin
    result  = sum;
    isArith = 1'b1;
    case (alu_op_e'(alu_bus.alu_control))
      ALU_AND: begin
        result  = alu_bus.src_a & alu_bus.src_b;
        isArith = 1'b0;
      end
      ALU_ORR: begin
        result  = alu_bus.src_a | alu_bus.src_b;
        isArith = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    flags         = 4'b0000;
    flags[FLAG_N] = result[WIDTH-1];
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_C] = isArith & cout;
    flags[FLAG_V] = isArith & ovf;
  end

  always_comb begin
    nz_d = alu_bus.flag_we[1] ? flags[FLAG_N:FLAG_Z] : nz_q;
    cv_d = alu_bus.flag_we[0] ? flags[FLAG_C:FLAG_V] : cv_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nz_q <= 2'b00;
      cv_q <= 2'b00;
    end else begin
      nz_q <= nz_d;
      cv_q <= cv_d;
    end
  end

  assign alu_bus.alu_result = result;
  assign alu_bus.alu_flags  = flags;
  assign alu_bus.flags_q    = {nz_q, cv_q};

endmodule

// File: tb/tb_arm_alu.sv
// Self-checking bench for arm_alu: directed literal cases, flags_q sequence,
// then randomized operands compared each cycle against a signed/unsigned arithmetic model.
module tb_arm_alu;
  import arm_alu_pkg::*;

  logic clk;
  logic reset;
  bit   enableCompare;
  int   checks;
  int   errors;
  logic [3:0] expFlagsQ;

  arm_alu_if #(.WIDTH(32)) bus ();

  arm_alu #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .alu_bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: result plus {N,Z,C,V} from plain integer arithmetic.
  function automatic logic [35:0] modelAlu(input logic [1:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] r;
    logic        c;
    logic        v;
    longint      sa;
    longint      sb;
    longint      full;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c  = 1'b0;
    v  = 1'b0;
    case (op)
      2'b00: begin
        r    = a + b;
        c    = (longint'({32'b0, a}) + longint'({32'b0, b})) > 64'sh0000_0000_FFFF_FFFF;
        full = sa + sb;
        v    = (full > 64'sd2147483647) || (full < -64'sd2147483648);
      end
      2'b01: begin
        r    = a - b;
        c    = (a >= b);
        full = sa - sb;
        v    = (full > 64'sd2147483647) || (full < -64'sd2147483648);
      end
      2'b10:   r = a & b;
      default: r = a | b;
    endcase
    return {r, r[31], (r == 32'd0), c, v};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [1:0] we);
    @(negedge clk);
    bus.alu_control = op;
    bus.src_a       = a;
    bus.src_b       = b;
    bus.flag_we     = we;
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Per-cycle compare: model updates flags_q on each edge, then outputs are checked 1ns later.
  always @(posedge clk or posedge reset) begin
    logic [35:0] exp;
    if (reset) begin
      expFlagsQ = 4'b0000;
    end else begin
      exp = modelAlu(bus.alu_control, bus.src_a, bus.src_b);
      if (bus.flag_we[1]) expFlagsQ[3:2] = exp[3:2];
      if (bus.flag_we[0]) expFlagsQ[1:0] = exp[1:0];
    end
    #1;
    if (enableCompare) begin
      exp = modelAlu(bus.alu_control, bus.src_a, bus.src_b);
      checkOutput("model_result", bus.alu_result, exp[35:4]);
      checkOutput("model_flags", {28'b0, bus.alu_flags}, {28'b0, exp[3:0]});
      checkOutput("model_flags_q", {28'b0, bus.flags_q}, {28'b0, expFlagsQ});
    end
  end

  initial begin
    logic [35:0] pin;
    checks          = 0;
    errors          = 0;
    enableCompare   = 1'b0;
    reset           = 1'b1;
    bus.src_a       = 32'd0;
    bus.src_b       = 32'd0;
    bus.alu_control = 2'b00;
    bus.flag_we     = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_flags_q", {28'b0, bus.flags_q}, 32'h0);
    reset         = 1'b0;
    enableCompare = 1'b1;

    // Literal cases pin both the DUT and the reference model.
    applyStimulus(ALU_ADD, 32'd5, 32'd7, 2'b00); #1;
    checkOutput("add_5_7_res", bus.alu_result, 32'h0000_000C);
    checkOutput("add_5_7_flg", {28'b0, bus.alu_flags}, 32'h0);
    pin = modelAlu(ALU_ADD, 32'd5, 32'd7);
    checkOutput("model_pin_add", pin[35:4], 32'h0000_000C);

    applyStimulus(ALU_SUB, 32'd7, 32'd7, 2'b00); #1;
    checkOutput("sub_7_7_res", bus.alu_result, 32'h0);
    checkOutput("sub_7_7_flg", {28'b0, bus.alu_flags}, 32'h6);

    applyStimulus(ALU_SUB, 32'd3, 32'd5, 2'b00); #1;
    checkOutput("sub_3_5_res", bus.alu_result, 32'hFFFF_FFFE);
    checkOutput("sub_3_5_flg", {28'b0, bus.alu_flags}, 32'h8);
    pin = modelAlu(ALU_SUB, 32'd3, 32'd5);
    checkOutput("model_pin_sub", {28'b0, pin[3:0]}, 32'h8);

    applyStimulus(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 2'b00); #1;
    checkOutput("add_ovf_res", bus.alu_result, 32'h8000_0000);
    checkOutput("add_ovf_flg", {28'b0, bus.alu_flags}, 32'h9);
    pin = modelAlu(ALU_ADD, 32'h7FFF_FFFF, 32'd1);
    checkOutput("model_pin_ovf", {28'b0, pin[3:0]}, 32'h9);

    applyStimulus(ALU_ADD, 32'hFFFF_FFFF, 32'd1, 2'b00); #1;
    checkOutput("add_wrap_res", bus.alu_result, 32'h0);
    checkOutput("add_wrap_flg", {28'b0, bus.alu_flags}, 32'h6);

    applyStimulus(ALU_AND, 32'h0000_F0F0, 32'h0000_FF00, 2'b00); #1;
    checkOutput("and_res", bus.alu_result, 32'h0000_F000);
    checkOutput("and_flg", {28'b0, bus.alu_flags}, 32'h0);

    applyStimulus(ALU_ORR, 32'h8000_0000, 32'd1, 2'b00); #1;
    checkOutput("orr_res", bus.alu_result, 32'h8000_0001);
    checkOutput("orr_flg", {28'b0, bus.alu_flags}, 32'h8);

    // Split-enable flags_q sequence and asynchronous clear.
    applyStimulus(ALU_SUB, 32'd7, 32'd7, 2'b10);
    @(posedge clk); #2;
    checkOutput("fq_nz_write", {28'b0, bus.flags_q}, 32'h4);
    applyStimulus(ALU_ADD, 32'hFFFF_FFFF, 32'd1, 2'b01);
    @(posedge clk); #2;
    checkOutput("fq_cv_write", {28'b0, bus.flags_q}, 32'h6);
    applyStimulus(ALU_ORR, 32'h8000_0000, 32'd1, 2'b00);
    @(posedge clk); #2;
    checkOutput("fq_hold", {28'b0, bus.flags_q}, 32'h6);
    reset = 1'b1;
    #1;
    checkOutput("fq_async_clear", {28'b0, bus.flags_q}, 32'h0);
    checkOutput("reset_comb_res", bus.alu_result, 32'h8000_0001);
    #1;
    reset = 1'b0;

    // Randomized operation mix with occasional one-cycle resets.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(2'($urandom_range(0, 3)), pickOperand(), pickOperand(),
                    2'($urandom_range(0, 3)));
      reset = ($urandom_range(0, 39) == 0);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
